tank_shell: RTL

Projectile controller for one tank. It sits directly downstream of the tank movement unit and consumes that unit's position, size and facing outputs. On a fire press it spawns a shell at the tank's muzzle and advances it once per frame. The shell is retired on a wall, a barrier or an enemy hit, and a cooldown follows before the next shot. Its outputs feed the color mapper (drawing) and the score/collision logic. One instance is used per player.

---
 rtl/tank_pkg.sv | 20 ++
 rtl/shell_muzzle.sv | 55 +++++
 rtl/tank_shell.sv | 108 ++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared tank constants: direction encoding, playfield bounds, shell FSM states
package tank_pkg;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  localparam int X_MIN = 1;
  localparam int X_MAX = 639;
  localparam int Y_MIN = 1;
  localparam int Y_MAX = 479;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLIGHT   = 2'd1,
    COOLDOWN = 2'd2
  } shell_state_t;

endpackage

// File: rtl/shell_muzzle.sv
// rtl/shell_muzzle.sv - combinational muzzle position and spawn-in-bounds check
module shell_muzzle
  import tank_pkg::*;
#(
  parameter int SHELL_SIZE = 2
) (
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [9:0] TankS,
  input  logic [1:0] direction,
  output logic [9:0] spawn_x,
  output logic [9:0] spawn_y,
  output logic       spawn_valid
);

  // 12-bit arithmetic; the backward case is only used once its bound check shows no underflow
  logic [11:0] cx, cy, back, fwd_x, rev_x, fwd_y, rev_y;

  assign cx    = {2'b00, TankX};
  assign cy    = {2'b00, TankY};
  assign back  = {2'b00, TankS} + 12'(SHELL_SIZE);
  assign fwd_x = cx + back;
  assign rev_x = cx - back;
  assign fwd_y = cy + back;
  assign rev_y = cy - back;

  always_comb begin
    spawn_x     = TankX;
    spawn_y     = TankY;
    spawn_valid = 1'b0;
    case (direction)
      DIR_LEFT: begin
        spawn_x     = rev_x[9:0];
        spawn_valid = (cx >= back + 12'(X_MIN + SHELL_SIZE)) &&
                      (cx + 12'(SHELL_SIZE) <= back + 12'(X_MAX));
      end
      DIR_RIGHT: begin
        spawn_x     = fwd_x[9:0];
        spawn_valid = (fwd_x >= 12'(X_MIN + SHELL_SIZE)) &&
                      (fwd_x + 12'(SHELL_SIZE) <= 12'(X_MAX));
      end
      DIR_DOWN: begin
        spawn_y     = fwd_y[9:0];
        spawn_valid = (fwd_y >= 12'(Y_MIN + SHELL_SIZE)) &&
                      (fwd_y + 12'(SHELL_SIZE) <= 12'(Y_MAX));
      end
      default: begin
        spawn_y     = rev_y[9:0];
        spawn_valid = (cy >= back + 12'(Y_MIN + SHELL_SIZE)) &&
                      (cy + 12'(SHELL_SIZE) <= back + 12'(Y_MAX));
      end
    endcase
  end

endmodule

// File: rtl/tank_shell.sv
// rtl/tank_shell.sv - per-player shell controller: fire edge detect, flight FSM, cooldown
module tank_shell
  import tank_pkg::*;
#(
  parameter int SHELL_STEP      = 4,
  parameter int SHELL_SIZE      = 2,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       fire,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [9:0] TankS,
  input  logic [1:0] direction,
  input  logic       barrier_collision,
  input  logic       enemy_hit,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic [9:0] ShellS,
  output logic       shell_active,
  output logic [1:0] shell_dir,
  output logic       score_pulse
);

  localparam int CW = $clog2(COOLDOWN_FRAMES) + 1;

  shell_state_t state, next_state;
  logic          fire_q, press, at_edge, active_d, pulse_d, spawn_valid;
  logic [9:0]    spawn_x, spawn_y;
  logic [10:0]   sx, sy;
  logic [CW-1:0] cnt;

  shell_muzzle #(.SHELL_SIZE(SHELL_SIZE)) u_muzzle (
    .TankX(TankX), .TankY(TankY), .TankS(TankS), .direction(direction),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_valid(spawn_valid)
  );

  assign ShellS = 10'(SHELL_SIZE);
  assign press  = fire && !fire_q;
  assign sx     = {1'b0, ShellX};
  assign sy     = {1'b0, ShellY};

  // Would the next step carry the shell outside the playfield?
  always_comb begin
    at_edge = 1'b0;
    case (shell_dir)
      DIR_LEFT:  at_edge = sx < 11'(X_MIN + SHELL_SIZE + SHELL_STEP);
      DIR_RIGHT: at_edge = sx + 11'(SHELL_SIZE + SHELL_STEP) > 11'(X_MAX);
      DIR_DOWN:  at_edge = sy + 11'(SHELL_SIZE + SHELL_STEP) > 11'(Y_MAX);
      default:   at_edge = sy < 11'(Y_MIN + SHELL_SIZE + SHELL_STEP);
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (press && spawn_valid) next_state = FLIGHT;
      FLIGHT:   if (enemy_hit || barrier_collision || at_edge) next_state = COOLDOWN;
      COOLDOWN: if (cnt <= CW'(1)) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    active_d = (next_state == FLIGHT);
    pulse_d  = (state == FLIGHT) && enemy_hit;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      fire_q       <= 1'b1;
      shell_active <= 1'b0;
      score_pulse  <= 1'b0;
      ShellX       <= '0;
      ShellY       <= '0;
      shell_dir    <= DIR_LEFT;
      cnt          <= '0;
    end else begin
      fire_q       <= fire;
      shell_active <= active_d;
      score_pulse  <= pulse_d;
      if (state == IDLE && next_state == FLIGHT) begin
        ShellX    <= spawn_x;
        ShellY    <= spawn_y;
        shell_dir <= direction;
      end else if (state == FLIGHT && next_state == FLIGHT) begin
        case (shell_dir)
          DIR_LEFT:  ShellX <= ShellX - 10'(SHELL_STEP);
          DIR_RIGHT: ShellX <= ShellX + 10'(SHELL_STEP);
          DIR_DOWN:  ShellY <= ShellY + 10'(SHELL_STEP);
          default:   ShellY <= ShellY - 10'(SHELL_STEP);
        endcase
      end
      // The counter reaches zero on the same edge that returns the FSM to IDLE
      if (state != COOLDOWN && next_state == COOLDOWN)
        cnt <= CW'(COOLDOWN_FRAMES - 1);
      else if (state == COOLDOWN && cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

endmodule
